// File: rtl/_pkg_riscv_defines.sv
// Shared bus widths and AXI field types used by the memory-mapped blocks.
package _pkg_riscv_defines;

  localparam int unsigned ADDR_WIDTH      = 32;
  localparam int unsigned DATA_WIDTH      = 32;
  localparam int unsigned AXI_ARLEN_WIDTH = 8;

  typedef logic [2:0] axi_size_t;

  typedef enum logic [1:0] {
    AXI_BURST_FIXED = 2'b00,
    AXI_BURST_INCR  = 2'b01,
    AXI_BURST_WRAP  = 2'b10,
    AXI_BURST_RSVD  = 2'b11
  } axi_burst_type_t;

  typedef enum logic [1:0] {
    AXI_RESP_OKAY   = 2'b00,
    AXI_RESP_EXOKAY = 2'b01,
    AXI_RESP_SLVERR = 2'b10,
    AXI_RESP_DECERR = 2'b11
  } axi_resp_t;

endpackage

// File: rtl/axi_mem_slave_if.sv
// AXI read (AR/R) and write (AW/W/B) channel bundles for axi_mem_slave.
interface axi_read_if;
  import _pkg_riscv_defines::*;

  logic [ADDR_WIDTH-1:0]      araddr;
  logic [AXI_ARLEN_WIDTH-1:0] arlen;
  axi_size_t                  arsize;
  axi_burst_type_t            arburst;
  logic                       arvalid;
  logic                       arready;
  logic [DATA_WIDTH-1:0]      rdata;
  logic                       rlast;
  axi_resp_t                  rresp;
  logic                       rvalid;
  logic                       rready;

  modport slave (
    input  araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rdata, rlast, rresp, rvalid
  );

  modport master (
    output araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rdata, rlast, rresp, rvalid
  );
endinterface

interface axi_write_if;
  import _pkg_riscv_defines::*;

  logic [ADDR_WIDTH-1:0]      awaddr;
  logic [AXI_ARLEN_WIDTH-1:0] awlen;
  axi_size_t                  awsize;
  axi_burst_type_t            awburst;
  logic                       awvalid;
  logic                       awready;
  logic [DATA_WIDTH-1:0]      wdata;
  logic [DATA_WIDTH/8-1:0]    wstrb;
  logic                       wlast;
  logic                       wvalid;
  logic                       wready;
  axi_resp_t                  bresp;
  logic                       bvalid;
  logic                       bready;

  modport slave (
    input  awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    output awready, wready, bresp, bvalid
  );

  modport master (
    output awaddr, awlen, awsize, awburst, awvalid, wdata, wstrb, wlast, wvalid, bready,
    input  awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_mem_slave.sv
// AXI memory slave: independent read and write burst FSMs sharing one
// dual-port word array with per-beat address/size/burst error checking.
module axi_mem_slave
  import _pkg_riscv_defines::*;
#(
  parameter int unsigned           MEM_WORDS    = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0000,
  parameter int unsigned           READ_LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  axi_read_if.slave  axi_r,
  axi_write_if.slave axi_w
);

  typedef logic [AXI_ARLEN_WIDTH-1:0] len_t;
  typedef logic [ADDR_WIDTH-1:0]      addr_t;

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned LSB    = $clog2(STRB_W);
  localparam int unsigned IDX_W  = $clog2(MEM_WORDS);

  localparam axi_size_t           FULL_SIZE = axi_size_t'(LSB);
  localparam addr_t               STEP      = addr_t'(STRB_W);
  localparam logic [ADDR_WIDTH:0] MEM_BYTES =
    (ADDR_WIDTH+1)'(MEM_WORDS) * (ADDR_WIDTH+1)'(STRB_W);
  localparam logic [3:0] LAT_M1 =
    (READ_LATENCY == 0) ? 4'd0 : 4'(READ_LATENCY - 1);

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  function automatic addr_t align(input addr_t a);
    return a & ~(STEP - addr_t'(1));
  endfunction

  function automatic addr_t next_addr(input addr_t a, input len_t len,
                                      input axi_burst_type_t burst);
    addr_t mask;
    mask = ((addr_t'(len) + addr_t'(1)) << LSB) - addr_t'(1);
    case (burst)
      AXI_BURST_FIXED: return a;
      AXI_BURST_WRAP:  return (a & ~mask) | ((a + STEP) & mask);
      default:         return a + STEP;
    endcase
  endfunction

  // An address below BASE_ADDR wraps to a huge offset, so one compare covers both ends.
  function automatic logic beat_err(input addr_t a, input axi_size_t size,
                                    input axi_burst_type_t burst, input len_t len);
    addr_t off;
    logic  range_bad;
    logic  wrap_bad;
    off       = a - BASE_ADDR;
    range_bad = ({1'b0, off} >= MEM_BYTES);
    wrap_bad  = (burst == AXI_BURST_WRAP) &&
                !((len == len_t'(1)) || (len == len_t'(3)) ||
                  (len == len_t'(7)) || (len == len_t'(15)));
    return range_bad || (size != FULL_SIZE) || wrap_bad;
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input addr_t a);
    addr_t off;
    off = a - BASE_ADDR;
    return off[IDX_W+LSB-1:LSB];
  endfunction

  // Handshake readiness only after the first clock edge out of reset.
  logic run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run <= 1'b0;
    else        run <= 1'b1;
  end

  // ---------------- read path ----------------
  logic [1:0]            r_state;
  addr_t                 r_addr;
  len_t                  r_len;
  len_t                  r_beat;
  axi_size_t             r_size;
  axi_burst_type_t       r_burst;
  logic [3:0]            r_wait;
  logic [DATA_WIDTH-1:0] rdata_q;
  axi_resp_t             rresp_q;
  logic                  rlast_q;

  logic            ar_hs;
  addr_t           r_next;
  logic            ld_en;
  addr_t           ld_addr;
  len_t            ld_beat;
  len_t            ld_len;
  axi_size_t       ld_size;
  axi_burst_type_t ld_burst;
  logic            ld_err;

  assign axi_r.arready = run && (r_state == R_IDLE);
  assign axi_r.rvalid  = (r_state == R_DATA);
  assign axi_r.rlast   = (r_state == R_DATA) && rlast_q;
  assign axi_r.rdata   = rdata_q;
  assign axi_r.rresp   = rresp_q;

  assign ar_hs  = axi_r.arvalid && axi_r.arready;
  assign r_next = next_addr(r_addr, r_len, r_burst);

  // Selects which beat gets loaded into the R output register this edge.
  always_comb begin
    ld_en    = 1'b0;
    ld_addr  = r_addr;
    ld_beat  = r_beat;
    ld_len   = r_len;
    ld_size  = r_size;
    ld_burst = r_burst;
    case (r_state)
      R_IDLE: begin
        if (ar_hs && (READ_LATENCY == 0)) begin
          ld_en    = 1'b1;
          ld_addr  = align(axi_r.araddr);
          ld_beat  = '0;
          ld_len   = axi_r.arlen;
          ld_size  = axi_r.arsize;
          ld_burst = axi_r.arburst;
        end
      end
      R_WAIT: ld_en = (r_wait == 4'd0);
      R_DATA: begin
        if (axi_r.rready && (r_beat != r_len)) begin
          ld_en   = 1'b1;
          ld_addr = r_next;
          ld_beat = r_beat + len_t'(1);
        end
      end
      default: ld_en = 1'b0;
    endcase
  end

  assign ld_err = beat_err(ld_addr, ld_size, ld_burst, ld_len);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_beat  <= '0;
      r_size  <= '0;
      r_burst <= AXI_BURST_FIXED;
      r_wait  <= '0;
      rdata_q <= '0;
      rresp_q <= AXI_RESP_OKAY;
      rlast_q <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_hs) begin
            r_addr  <= align(axi_r.araddr);
            r_len   <= axi_r.arlen;
            r_size  <= axi_r.arsize;
            r_burst <= axi_r.arburst;
            r_beat  <= '0;
            r_wait  <= LAT_M1;
            r_state <= (READ_LATENCY == 0) ? R_DATA : R_WAIT;
          end
        end
        R_WAIT: begin
          if (r_wait == 4'd0) r_state <= R_DATA;
          else                r_wait  <= r_wait - 4'd1;
        end
        R_DATA: begin
          if (axi_r.rready) begin
            if (r_beat == r_len) begin
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_next;
              r_beat <= r_beat + len_t'(1);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
      // Sampling the array here returns pre-write data on a same-cycle collision.
      if (ld_en) begin
        rdata_q <= ld_err ? '0 : mem[word_idx(ld_addr)];
        rresp_q <= ld_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        rlast_q <= (ld_beat == ld_len);
      end
    end
  end

  // ---------------- write path ----------------
  logic [1:0]      w_state;
  addr_t           w_addr;
  len_t            w_len;
  len_t            w_beat;
  axi_size_t       w_size;
  axi_burst_type_t w_burst;
  logic            w_err;
  axi_resp_t       bresp_q;

  logic aw_hs;
  logic w_hs;
  logic w_beat_err;
  logic w_last_beat;
  logic w_bad;

  assign axi_w.awready = run && (w_state == W_IDLE);
  assign axi_w.wready  = (w_state == W_DATA);
  assign axi_w.bvalid  = (w_state == W_RESP);
  assign axi_w.bresp   = bresp_q;

  assign aw_hs       = axi_w.awvalid && axi_w.awready;
  assign w_hs        = axi_w.wvalid && axi_w.wready;
  assign w_beat_err  = beat_err(w_addr, w_size, w_burst, w_len);
  assign w_last_beat = (w_beat == w_len);
  assign w_bad       = w_beat_err || (axi_w.wlast != w_last_beat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_beat  <= '0;
      w_size  <= '0;
      w_burst <= AXI_BURST_FIXED;
      w_err   <= 1'b0;
      bresp_q <= AXI_RESP_OKAY;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_hs) begin
            w_addr  <= align(axi_w.awaddr);
            w_len   <= axi_w.awlen;
            w_size  <= axi_w.awsize;
            w_burst <= axi_w.awburst;
            w_beat  <= '0;
            w_err   <= 1'b0;
            w_state <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (w_last_beat) begin
              bresp_q <= (w_err || w_bad) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              w_addr <= next_addr(w_addr, w_len, w_burst);
              w_beat <= w_beat + len_t'(1);
              w_err  <= w_err || w_bad;
            end
          end
        end
        W_RESP: begin
          if (axi_w.bready) w_state <= W_IDLE;
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Array contents survive reset; the FSM reset alone blocks further writes.
  always_ff @(posedge clk) begin
    if (w_hs && !w_beat_err) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (axi_w.wstrb[b]) mem[word_idx(w_addr)][8*b +: 8] <= axi_w.wdata[8*b +: 8];
      end
    end
  end

  a_r_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (axi_r.rvalid && !axi_r.rready) |=> (axi_r.rvalid && $stable(axi_r.rdata)));
  a_b_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (axi_w.bvalid && !axi_w.bready) |=> (axi_w.bvalid && $stable(axi_w.bresp)));

endmodule

// File: tb/tb_axi_mem_slave.sv
// Scoreboard bench for axi_mem_slave: bursts, backpressure, strobes, WRAP,
// error responses and mid-burst reset, checked against a byte-lane model.
module tb_axi_mem_slave;
  import _pkg_riscv_defines::*;

  localparam int unsigned           MEM_WORDS    = 1024;
  localparam logic [ADDR_WIDTH-1:0] BASE_ADDR    = 32'h0000_0000;
  localparam int unsigned           READ_LATENCY = 2;
  localparam int unsigned           TMO          = 50;

  typedef struct {
    logic [DATA_WIDTH-1:0] data;
    axi_resp_t             resp;
    logic                  last;
  } rbeat_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  axi_read_if  r_if ();
  axi_write_if w_if ();

  axi_mem_slave #(
    .MEM_WORDS   (MEM_WORDS),
    .BASE_ADDR   (BASE_ADDR),
    .READ_LATENCY(READ_LATENCY)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .axi_r(r_if),
    .axi_w(w_if)
  );

  logic [DATA_WIDTH-1:0] model [MEM_WORDS];
  rbeat_t                rd_exp [$];
  axi_resp_t             wr_exp [$];
  int unsigned           n_tests = 0;
  int unsigned           n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] beat_addr(input logic [31:0] start, input int unsigned len,
                                            input axi_burst_type_t bt, input int unsigned i);
    logic [31:0] a, span, base;
    a = start & 32'hFFFF_FFFC;
    span = (len + 1) * 4;
    base = a - (a % span);
    case (bt)
      AXI_BURST_FIXED: return a;
      AXI_BURST_WRAP:  return base + ((a - base + i * 4) % span);
      default:         return a + i * 4;
    endcase
  endfunction

  function automatic bit beat_bad(input logic [31:0] a, input logic [2:0] size,
                                  input axi_burst_type_t bt, input int unsigned len);
    longint unsigned lo, hi, aa;
    lo = longint'(BASE_ADDR);
    hi = lo + longint'(MEM_WORDS) * 4;
    aa = longint'(a);
    return (aa < lo) || (aa >= hi) || (size != 3'd2) ||
           ((bt == AXI_BURST_WRAP) && !(len inside {1, 3, 7, 15}));
  endfunction

  function automatic int unsigned midx(input logic [31:0] a);
    return (a - BASE_ADDR) >> 2;
  endfunction

  task automatic idle_inputs();
    r_if.araddr = '0; r_if.arlen = '0; r_if.arsize = '0;
    r_if.arburst = AXI_BURST_FIXED; r_if.arvalid = 1'b0; r_if.rready = 1'b0;
    w_if.awaddr = '0; w_if.awlen = '0; w_if.awsize = '0;
    w_if.awburst = AXI_BURST_FIXED; w_if.awvalid = 1'b0;
    w_if.wdata = '0; w_if.wstrb = '0; w_if.wlast = 1'b0; w_if.wvalid = 1'b0;
    w_if.bready = 1'b0;
  endtask

  // Beat i carries d0+i; wlast is driven on beat last_at; only `send` beats are issued.
  task automatic axi_write(input logic [31:0] addr, input int unsigned len, input axi_burst_type_t bt,
                           input logic [2:0] size, input logic [31:0] d0, input logic [3:0] strb,
                           input int unsigned last_at, input int unsigned send);
    int unsigned cnt;
    logic [31:0] ba, d;
    bit err;
    err = 1'b0;
    @(negedge clk);
    w_if.awaddr = addr; w_if.awlen = AXI_ARLEN_WIDTH'(len);
    w_if.awsize = size; w_if.awburst = bt; w_if.awvalid = 1'b1;
    cnt = 0;
    while (!w_if.awready && cnt < TMO) begin @(negedge clk); cnt++; end
    chk("aw_wait", 64'(cnt < TMO), 64'd1);
    @(negedge clk);
    w_if.awvalid = 1'b0;
    for (int unsigned i = 0; i < send; i++) begin
      ba = beat_addr(addr, len, bt, i);
      d  = d0 + i;
      w_if.wvalid = 1'b1; w_if.wdata = d; w_if.wstrb = strb; w_if.wlast = (i == last_at);
      cnt = 0;
      while (!w_if.wready && cnt < TMO) begin @(negedge clk); cnt++; end
      chk("w_wait", 64'(cnt < TMO), 64'd1);
      if (beat_bad(ba, size, bt, len)) err = 1'b1;
      else
        for (int unsigned b = 0; b < 4; b++)
          if (strb[b]) model[midx(ba)][8*b +: 8] = d[8*b +: 8];
      if ((i == last_at) != (i == len)) err = 1'b1;
      if (i == len) wr_exp.push_back(err ? AXI_RESP_SLVERR : AXI_RESP_OKAY);
      @(negedge clk);
    end
    w_if.wvalid = 1'b0; w_if.wlast = 1'b0;
    if (send == len + 1) begin
      chk("bvalid_next", 64'(w_if.bvalid), 64'd1);
      cnt = 0;
      while (!w_if.bvalid && cnt < TMO) begin @(negedge clk); cnt++; end
      if (wr_exp.size() > 0) chk("bresp", 64'(w_if.bresp), 64'(wr_exp.pop_front()));
      else chk("wr_sb_empty", 64'd0, 64'd1);
      w_if.bready = 1'b1;
      @(negedge clk);
      w_if.bready = 1'b0;
      chk("bvalid_clr", 64'(w_if.bvalid), 64'd0);
      chk("awready_back", 64'(w_if.awready), 64'd1);
    end
  endtask

  // rpat bit n is rready in the n-th cycle after the first rvalid; `take` beats are accepted.
  task automatic axi_read(input logic [31:0] addr, input int unsigned len, input axi_burst_type_t bt,
                          input logic [2:0] size, input logic [15:0] rpat, input int unsigned take);
    int unsigned cnt, lat, got, cyc;
    logic [31:0] ba;
    rbeat_t e;
    bit rr;
    for (int unsigned i = 0; i <= len; i++) begin
      ba = beat_addr(addr, len, bt, i);
      if (beat_bad(ba, size, bt, len)) e.data = '0;
      else                             e.data = model[midx(ba)];
      e.resp = beat_bad(ba, size, bt, len) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      e.last = (i == len);
      rd_exp.push_back(e);
    end
    @(negedge clk);
    r_if.araddr = addr; r_if.arlen = AXI_ARLEN_WIDTH'(len);
    r_if.arsize = size; r_if.arburst = bt; r_if.arvalid = 1'b1;
    cnt = 0;
    while (!r_if.arready && cnt < TMO) begin @(negedge clk); cnt++; end
    chk("ar_wait", 64'(cnt < TMO), 64'd1);
    @(negedge clk);
    r_if.arvalid = 1'b0;
    lat = 1;
    while (!r_if.rvalid && lat < TMO) begin @(negedge clk); lat++; end
    chk("r_latency", 64'(lat), 64'(READ_LATENCY + 1));
    got = 0; cyc = 0;
    while (got < take && cyc < TMO) begin
      rr = (cyc < 16) ? rpat[cyc] : 1'b1;
      r_if.rready = rr;
      chk("rvalid", 64'(r_if.rvalid), 64'd1);
      if (r_if.rvalid && rd_exp.size() > 0) begin
        e = rd_exp[0];
        chk("rdata", 64'(r_if.rdata), 64'(e.data));
        chk("rresp", 64'(r_if.rresp), 64'(e.resp));
        chk("rlast", 64'(r_if.rlast), 64'(e.last));
        if (rr) begin
          void'(rd_exp.pop_front());
          got++;
        end
      end
      @(negedge clk);
      cyc++;
    end
    r_if.rready = 1'b0;
    chk("r_beats", 64'(got), 64'(take));
    if (take == len + 1) begin
      chk("rvalid_end", 64'(r_if.rvalid), 64'd0);
      chk("arready_back", 64'(r_if.arready), 64'd1);
    end
  endtask

  task automatic reset_now();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    chk("rst_rvalid", 64'(r_if.rvalid), 64'd0);
    chk("rst_bvalid", 64'(w_if.bvalid), 64'd0);
    chk("rst_wready", 64'(w_if.wready), 64'd0);
    chk("rst_arready", 64'(r_if.arready), 64'd0);
    chk("rst_awready", 64'(w_if.awready), 64'd0);
    chk("rst_rlast", 64'(r_if.rlast), 64'd0);
    chk("rst_rdata", 64'(r_if.rdata), 64'd0);
    chk("rst_rresp", 64'(r_if.rresp), 64'(AXI_RESP_OKAY));
    chk("rst_bresp", 64'(w_if.bresp), 64'(AXI_RESP_OKAY));
    rd_exp.delete();
    wr_exp.delete();
    repeat (2) @(negedge clk);
    chk("rst_hold_rvalid", 64'(r_if.rvalid), 64'd0);
    chk("rst_hold_bvalid", 64'(w_if.bvalid), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("arready_rise", 64'(r_if.arready), 64'd1);
    chk("awready_rise", 64'(w_if.awready), 64'd1);
  endtask

  initial begin
    idle_inputs();
    @(negedge clk);
    reset_now();

    axi_write(32'h10, 3, AXI_BURST_INCR, 3'd2, 32'hA0, 4'hF, 3, 4);
    axi_read (32'h10, 3, AXI_BURST_INCR, 3'd2, 16'hFFFF, 4);
    axi_read (32'h10, 3, AXI_BURST_INCR, 3'd2, 16'hFFF9, 4);

    axi_write(32'h20, 0, AXI_BURST_INCR, 3'd2, 32'h1122_3344, 4'hF, 0, 1);
    axi_write(32'h20, 0, AXI_BURST_INCR, 3'd2, 32'hAABB_CCDD, 4'b0101, 0, 1);
    chk("strb_model", 64'(model[midx(32'h20)]), 64'h11BB_33DD);
    axi_read (32'h20, 0, AXI_BURST_INCR, 3'd2, 16'hFFFF, 1);

    axi_write(32'h38, 3, AXI_BURST_WRAP, 3'd2, 32'hD0, 4'hF, 3, 4);
    axi_read (32'h30, 3, AXI_BURST_INCR, 3'd2, 16'hFFFF, 4);
    axi_read (32'h38, 3, AXI_BURST_WRAP, 3'd2, 16'hFFFF, 4);
    axi_write(32'h38, 2, AXI_BURST_WRAP, 3'd2, 32'hE0, 4'hF, 2, 3);
    axi_read (32'h30, 3, AXI_BURST_INCR, 3'd2, 16'hFFFF, 4);
    axi_read (32'h38, 2, AXI_BURST_WRAP, 3'd2, 16'hFFFF, 3);

    axi_read (BASE_ADDR + MEM_WORDS * 4, 0, AXI_BURST_INCR, 3'd2, 16'hFFFF, 1);
    axi_write(32'hFF8, 1, AXI_BURST_INCR, 3'd2, 32'hF8, 4'hF, 1, 2);
    axi_read (32'hFF8, 3, AXI_BURST_INCR, 3'd2, 16'hFFFF, 4);
    axi_write(32'h50, 3, AXI_BURST_INCR, 3'd2, 32'h50, 4'hF, 1, 4);
    axi_read (32'h50, 3, AXI_BURST_INCR, 3'd2, 16'hFFFF, 4);

    axi_write(32'h60, 0, AXI_BURST_INCR, 3'd2, 32'h6060_6060, 4'hF, 0, 1);
    axi_write(32'h60, 0, AXI_BURST_INCR, 3'd1, 32'hDEAD_BEEF, 4'hF, 0, 1);
    axi_read (32'h60, 0, AXI_BURST_INCR, 3'd2, 16'hFFFF, 1);
    axi_read (32'h60, 0, AXI_BURST_INCR, 3'd1, 16'hFFFF, 1);

    axi_write(32'h70, 2, AXI_BURST_FIXED, 3'd2, 32'h70, 4'hF, 2, 3);
    axi_read (32'h70, 1, AXI_BURST_FIXED, 3'd2, 16'hFFFF, 2);
    axi_read (32'h13, 0, AXI_BURST_INCR, 3'd2, 16'hFFFF, 1);

    axi_read (32'h10, 3, AXI_BURST_INCR, 3'd2, 16'hFFFF, 1);
    reset_now();
    axi_write(32'h40, 3, AXI_BURST_INCR, 3'd2, 32'hC0, 4'hF, 3, 2);
    chk("w_data_wready", 64'(w_if.wready), 64'd1);
    reset_now();
    axi_read (32'h10, 3, AXI_BURST_INCR, 3'd2, 16'hFFFF, 4);
    axi_read (32'h40, 1, AXI_BURST_INCR, 3'd2, 16'hFFFF, 2);

    chk("rd_sb_drained", 64'(rd_exp.size()), 64'd0);
    chk("wr_sb_drained", 64'(wr_exp.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
